wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: merges pipeline writeback and long-latency (mul/div) results onto one RF write port.
// Latency: a grant in cycle N appears on rf_wr_* in cycle N+1; LU results wait at least one cycle in a 2-entry FIFO.
// Backpressure: lu_ready drops while the FIFO is full; pipe_stall asserts only when a forced LU grant beats the pipe.
//
// Ports:
//   clk, rst_n                               clock, async active-low reset
//   pipe_wr_en/addr/data, pipe_stall         pipeline writeback request and hold
//   lu_valid/addr/data, lu_ready             long-latency unit result handshake
//   rf_wr_en/addr/data                       registered register-file write port
//   lu_pending                               registered "LU FIFO non-empty"
//
// Optional feature: define WB_STARVE_GUARD_EN to build in the starvation guard.
// Without it the pipeline always wins and LU results drain only in pipe-idle cycles.

module wb_port_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pipe_wr_en,
   input  logic [4:0]  pipe_wr_addr,
   input  logic [31:0] pipe_wr_data,
   output logic        pipe_stall,
   input  logic        lu_valid,
   input  logic [4:0]  lu_addr,
   input  logic [31:0] lu_data,
   output logic        lu_ready,
   output logic        rf_wr_en,
   output logic [4:0]  rf_wr_addr,
   output logic [31:0] rf_wr_data,
   output logic        lu_pending
);

   typedef enum logic {ARB_PIPE, ARB_FORCE} arb_state_t;

   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_check
      $error("wb_port_arbiter: STARVE_LIMIT must be in 1..15");
   end

   // LU result FIFO (2 entries)
   logic [4:0]  fifo_addr [2];
   logic [31:0] fifo_data [2];
   logic        wr_ptr;
   logic        rd_ptr;
   logic [1:0]  count;
   logic [1:0]  count_nxt;

   logic        pipe_req;
   logic        fifo_ne;
   logic        lu_push;
   logic        grant_pipe;
   logic        grant_head;
   arb_state_t  state;

   // Writes to x0 are not requests at all: never stalled, never written.
   assign pipe_req = pipe_wr_en && (pipe_wr_addr != 5'd0);
   assign fifo_ne  = (count != 2'd0);

   // Ready comes from the registered count only, so a same-cycle pop never
   // opens the door for a push into a full FIFO.
   assign lu_ready = (count != 2'd2);

   // x0 results are accepted (handshake completes) but silently dropped.
   assign lu_push  = lu_valid && lu_ready && (lu_addr != 5'd0);

   // Only registered FIFO contents are eligible, so a result pushed this
   // cycle cannot be granted before next cycle.
   always_comb begin
      grant_pipe = 1'b0;
      grant_head = 1'b0;
      if (state == ARB_FORCE && fifo_ne) begin
         grant_head = 1'b1;
      end else if (pipe_req) begin
         grant_pipe = 1'b1;
      end else if (fifo_ne) begin
         grant_head = 1'b1;
      end
   end

   always_comb begin
      count_nxt = count;
      case ({lu_push, grant_head})
         2'b10:   count_nxt = count + 2'd1;
         2'b01:   count_nxt = count - 2'd1;
         default: count_nxt = count;
      endcase
   end

`ifdef WB_STARVE_GUARD_EN
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   arb_state_t state_nxt;
   logic [3:0] starve_cnt;
   logic [3:0] starve_nxt;

   // Counts consecutive cycles the FIFO head waited while non-empty; once it
   // reaches the limit the following cycle belongs to the head.
   always_comb begin
      state_nxt  = state;
      starve_nxt = starve_cnt;
      if (grant_head || !fifo_ne) begin
         starve_nxt = 4'd0;
      end else if (starve_cnt != 4'hF) begin
         starve_nxt = starve_cnt + 4'd1;
      end
      if (state == ARB_PIPE) begin
         if (fifo_ne && !grant_head && starve_nxt >= LIMIT) begin
            state_nxt = ARB_FORCE;
         end
      end else begin
         // One forced head grant, then back to pipe priority.
         if (grant_head || !fifo_ne) begin
            state_nxt = ARB_PIPE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ARB_PIPE;
         starve_cnt <= 4'd0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_nxt;
      end
   end

   assign pipe_stall = pipe_req && grant_head;
`else
   assign state      = ARB_PIPE;
   assign pipe_stall = 1'b0;
`endif

   // FIFO storage: contents are don't-care while count says empty.
   always_ff @(posedge clk) begin
      if (lu_push) begin
         fifo_addr[wr_ptr] <= lu_addr;
         fifo_data[wr_ptr] <= lu_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         count      <= 2'd0;
         lu_pending <= 1'b0;
         rf_wr_en   <= 1'b0;
         rf_wr_addr <= 5'd0;
         rf_wr_data <= 32'd0;
      end else begin
         if (lu_push) begin
            wr_ptr <= ~wr_ptr;
         end
         if (grant_head) begin
            rd_ptr <= ~rd_ptr;
         end
         count      <= count_nxt;
         lu_pending <= (count_nxt != 2'd0);

         // Address/data hold their last value on idle cycles.
         rf_wr_en <= grant_pipe || grant_head;
         if (grant_head) begin
            rf_wr_addr <= fifo_addr[rd_ptr];
            rf_wr_data <= fifo_data[rd_ptr];
         end else if (grant_pipe) begin
            rf_wr_addr <= pipe_wr_addr;
            rf_wr_data <= pipe_wr_data;
         end
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

   logic        clk;
   logic        rst_n;
   logic        pipe_wr_en;
   logic [4:0]  pipe_wr_addr;
   logic [31:0] pipe_wr_data;
   logic        pipe_stall;
   logic        lu_valid;
   logic [4:0]  lu_addr;
   logic [31:0] lu_data;
   logic        lu_ready;
   logic        rf_wr_en;
   logic [4:0]  rf_wr_addr;
   logic [31:0] rf_wr_data;
   logic        lu_pending;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        pe;
      logic [4:0]  pa;
      logic [31:0] pd;
      logic        lv;
      logic [4:0]  la;
      logic [31:0] ld;
      logic        stall;
      logic        rdy;
      logic        pend;
      logic        wr;
      logic [4:0]  wa;
      logic [31:0] wd;
   } vec_t;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;

   wr_t  exp_q[$];
   vec_t tbl[$];

   wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pipe_wr_en   (pipe_wr_en),
      .pipe_wr_addr (pipe_wr_addr),
      .pipe_wr_data (pipe_wr_data),
      .pipe_stall   (pipe_stall),
      .lu_valid     (lu_valid),
      .lu_addr      (lu_addr),
      .lu_data      (lu_data),
      .lu_ready     (lu_ready),
      .rf_wr_en     (rf_wr_en),
      .rf_wr_addr   (rf_wr_addr),
      .rf_wr_data   (rf_wr_data),
      .lu_pending   (lu_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input int pe, input int pa, input int pd,
                               input int lv, input int la, input int ld,
                               input int stall, input int rdy, input int pend,
                               input int wr, input int wa, input int wd);
      vec_t v;
      v.pe = 1'(pe);  v.pa = 5'(pa);  v.pd = 32'(pd);
      v.lv = 1'(lv);  v.la = 5'(la);  v.ld = 32'(ld);
      v.stall = 1'(stall); v.rdy = 1'(rdy); v.pend = 1'(pend);
      v.wr = 1'(wr);  v.wa = 5'(wa);  v.wd = 32'(wd);
      return v;
   endfunction

   // Drive one cycle of stimulus, record the write this cycle's grant should
   // produce, and check the same-cycle outputs.
   task automatic apply(input vec_t v, input string tag);
      wr_t w;
      @(posedge clk);
      #1;
      pipe_wr_en   = v.pe;
      pipe_wr_addr = v.pa;
      pipe_wr_data = v.pd;
      lu_valid     = v.lv;
      lu_addr      = v.la;
      lu_data      = v.ld;
      if (v.wr) begin
         w.a = v.wa;
         w.d = v.wd;
         exp_q.push_back(w);
      end
      #2;
      chk({tag, "_stall"}, 32'(pipe_stall), 32'(v.stall));
      chk({tag, "_lu_ready"}, 32'(lu_ready), 32'(v.rdy));
      chk({tag, "_lu_pending"}, 32'(lu_pending), 32'(v.pend));
   endtask

   // Scoreboard: every RF write must match the oldest expected write.
   always @(negedge clk) begin
      if (rf_wr_en) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write got addr=%0h data=%0h want none at %0t",
                     rf_wr_addr, rf_wr_data, $time);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_addr", 32'(rf_wr_addr), 32'(e.a));
            chk("wr_data", rf_wr_data, e.d);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout got=running want=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      rst_n        = 1'b1;
      pipe_wr_en   = 1'b0;
      pipe_wr_addr = 5'd0;
      pipe_wr_data = 32'd0;
      lu_valid     = 1'b0;
      lu_addr      = 5'd0;
      lu_data      = 32'd0;

      // basic / x0 / push+pop / pipe-addr-0 cases
      tbl.push_back(mk(0, 0, 0,       0, 0, 0,        0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 'h11,    0, 0, 0,        0, 1, 0, 1, 1, 'h11));
      tbl.push_back(mk(0, 0, 0,       1, 5, 'h1234,   0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0,       0, 0, 0,        0, 1, 1, 1, 5, 'h1234));
      tbl.push_back(mk(1, 0, 'hdead,  1, 0, 'hbeef,   0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 'hdead,  1, 0, 'hbeef,   0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0,       0, 0, 0,        0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(1, 2, 'h22,    1, 9, 'h99,     0, 1, 0, 1, 2, 'h22));
      tbl.push_back(mk(1, 3, 'h33,    0, 0, 0,        0, 1, 1, 1, 3, 'h33));
      tbl.push_back(mk(0, 0, 0,       1, 10, 'hAA,    0, 1, 1, 1, 9, 'h99));
      tbl.push_back(mk(0, 0, 0,       0, 0, 0,        0, 1, 1, 1, 10, 'hAA));
      tbl.push_back(mk(0, 0, 0,       0, 0, 0,        0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0,       1, 4, 'h44,     0, 1, 0, 0, 0, 0));
      tbl.push_back(mk(1, 0, 'h55,    0, 0, 0,        0, 1, 1, 1, 4, 'h44));
      tbl.push_back(mk(0, 0, 0,       0, 0, 0,        0, 1, 0, 0, 0, 0));
      // backpressure: three back-to-back LU results while pipe busy
      tbl.push_back(mk(1, 1, 'h100,   1, 11, 'hB1,    0, 1, 0, 1, 1, 'h100));
      tbl.push_back(mk(1, 1, 'h101,   1, 12, 'hB2,    0, 1, 1, 1, 1, 'h101));
      tbl.push_back(mk(1, 1, 'h102,   1, 13, 'hB3,    0, 0, 1, 1, 1, 'h102));
      tbl.push_back(mk(0, 0, 0,       1, 13, 'hB3,    0, 0, 1, 1, 11, 'hB1));
      tbl.push_back(mk(0, 0, 0,       1, 13, 'hB3,    0, 1, 1, 1, 12, 'hB2));
      tbl.push_back(mk(0, 0, 0,       0, 0, 0,        0, 1, 1, 1, 13, 'hB3));
      tbl.push_back(mk(0, 0, 0,       0, 0, 0,        0, 1, 0, 0, 0, 0));

      // reset values, asserted asynchronously before any clock activity
      #2 rst_n = 1'b0;
      #1;
      chk("rst_rf_wr_en",   32'(rf_wr_en), 32'd0);
      chk("rst_rf_wr_addr", 32'(rf_wr_addr), 32'd0);
      chk("rst_rf_wr_data", rf_wr_data, 32'd0);
      chk("rst_lu_pending", 32'(lu_pending), 32'd0);
      chk("rst_lu_ready",   32'(lu_ready), 32'd1);
      chk("rst_pipe_stall", 32'(pipe_stall), 32'd0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i], $sformatf("vec%0d", i));
      end

      // collision: pipe writes x3 every cycle while one LU result waits
      for (int c = 0; c < 10; c++) begin
         v = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
         if (c < 8) begin
            v.pe = 1'b1; v.pa = 5'd3; v.pd = 32'hA;
         end
         if (c == 0) begin
            v.lv = 1'b1; v.la = 5'd7; v.ld = 32'hB;
         end
`ifdef WB_STARVE_GUARD_EN
         v.stall = (c == 5);
         v.pend  = (c >= 1 && c <= 5);
         if (c == 5) begin
            v.wr = 1'b1; v.wa = 5'd7; v.wd = 32'hB;
         end else if (c < 8) begin
            v.wr = 1'b1; v.wa = 5'd3; v.wd = 32'hA;
         end
`else
         v.pend = (c >= 1 && c <= 8);
         if (c < 8) begin
            v.wr = 1'b1; v.wa = 5'd3; v.wd = 32'hA;
         end else if (c == 8) begin
            v.wr = 1'b1; v.wa = 5'd7; v.wd = 32'hB;
         end
`endif
         apply(v, $sformatf("coll%0d", c));
      end

      // reset mid-stream with two LU results buffered
      apply(mk(1, 1, 'h200, 1, 20, 'hC0, 0, 1, 0, 1, 1, 'h200), "rs0");
      apply(mk(1, 1, 'h201, 1, 21, 'hC1, 0, 1, 1, 1, 1, 'h201), "rs1");
      apply(mk(1, 1, 'h202, 0, 0, 0,     0, 0, 1, 0, 0, 0),     "rs2");
      #4;
      rst_n      = 1'b0;
      pipe_wr_en = 1'b0;
      lu_valid   = 1'b0;
      #1;
      chk("mid_rst_rf_wr_en",   32'(rf_wr_en), 32'd0);
      chk("mid_rst_lu_pending", 32'(lu_pending), 32'd0);
      chk("mid_rst_lu_ready",   32'(lu_ready), 32'd1);
      repeat (2) begin
         @(posedge clk);
         #1;
         chk("in_rst_rf_wr_en", 32'(rf_wr_en), 32'd0);
         chk("in_rst_lu_ready", 32'(lu_ready), 32'd1);
      end
      #2 rst_n = 1'b1;
      apply(mk(0, 0, 0,      0, 0, 0, 0, 1, 0, 0, 0, 0),      "post_rst0");
      apply(mk(1, 4, 'h300,  0, 0, 0, 0, 1, 0, 1, 4, 'h300),  "post_rst1");
      apply(mk(0, 0, 0,      0, 0, 0, 0, 1, 0, 0, 0, 0),      "post_rst2");
      apply(mk(0, 0, 0,      0, 0, 0, 0, 1, 0, 0, 0, 0),      "post_rst3");

      chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
